// File: rtl/log_test_clk_burst_if.sv
// Boundary-scan side bundle for the logic-test clock burst generator.
// The master drives the TAP strobe, mode and channel controls.
// The slave returns the gated test clocks and the burst status.
interface log_test_clk_burst_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic             Update_DR;
    logic             Mode;
    logic [N_CH-1:0]  From_BSC;
    logic [N_CH-1:0]  Ch_en;
    logic [CNT_W-1:0] Pulse_count;
    logic [N_CH-1:0]  Test_clk;
    logic             Busy;
    logic             Done;

    modport master (
        output Update_DR, Mode, From_BSC, Ch_en, Pulse_count,
        input  Test_clk, Busy, Done
    );

    modport slave (
        input  Update_DR, Mode, From_BSC, Ch_en, Pulse_count,
        output Test_clk, Busy, Done
    );
endinterface

// File: rtl/log_test_clk_burst.sv
// Multi-channel logic-test clock generator.
// A rising edge of Update_DR, synchronised into TCK, launches a burst of
// Pulse_count single-cycle gate pulses spaced two TCK apart.  The gate is
// ANDed with each enabled channel's From_BSC clock.  In bypass mode every
// From_BSC bit passes straight through to Test_clk.
module log_test_clk_burst #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input logic              TCK,
    input logic              Reset,
    log_test_clk_burst_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [1:0]       state;
    logic             gate;
    logic [CNT_W-1:0] rem;
    logic             done_r;

    // s1/s2 resolve metastability; s3 is the delayed copy for edge detection.
    assign rise = s2 & ~s3;

    // Three-flop shift of the asynchronous Update_DR strobe into TCK.
    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.Update_DR;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Burst sequencer: gate alternates high/low until rem pulses are spent.
    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            gate   <= 1'b0;
            rem    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (rise && bus.Mode) begin
                        if (bus.Pulse_count != '0) begin
                            state <= ST_BURST;
                            rem   <= bus.Pulse_count;
                            gate  <= 1'b1;
                        end else begin
                            // Zero-length burst still reports completion.
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (!bus.Mode) begin
                        // Leaving test mode discards the burst silently.
                        state <= ST_IDLE;
                        gate  <= 1'b0;
                        rem   <= '0;
                    end else if (gate) begin
                        gate <= 1'b0;
                        rem  <= rem - 1'b1;
                    end else if (rem != '0) begin
                        gate <= 1'b1;
                    end else begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Rises seen here are dropped; a fresh edge is required.
                    state  <= ST_IDLE;
                    done_r <= 1'b0;
                    gate   <= 1'b0;
                    rem    <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    gate   <= 1'b0;
                    rem    <= '0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Gate and Ch_en act immediately, so reset or masking cuts pulses at once.
    assign bus.Test_clk = bus.Mode ? (bus.From_BSC & bus.Ch_en & {N_CH{gate}})
                                   : bus.From_BSC;
    assign bus.Busy     = (state == ST_BURST);
    assign bus.Done     = done_r;

endmodule

// File: tb/tb_log_test_clk_burst.sv
// Self-checking bench for log_test_clk_burst.
// The reference model keeps the sampled Update_DR history and describes a
// burst as a start edge plus a pulse count; expected outputs are derived
// from that schedule every cycle.
module tb_log_test_clk_burst;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;

    logic TCK = 1'b0;
    logic Reset;

    log_test_clk_burst_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    log_test_clk_burst #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .TCK   (TCK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 TCK = ~TCK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit upd_q[$];
    int ec;
    bit m_active;
    int m_start;
    int m_n;
    int m_done_edge;

    // Observation counters for burst-level checks
    int pulse_cnt;
    int side_cnt;
    int done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit upd_at(input int k);
        if (k < 0 || k >= upd_q.size()) return 1'b0;
        return upd_q[k];
    endfunction

    task automatic model_reset();
        upd_q.delete();
        ec          = 0;
        m_active    = 1'b0;
        m_start     = 0;
        m_n         = 0;
        m_done_edge = -100;
    endtask

    // Advance the schedule by one TCK edge using the inputs sampled there.
    task automatic model_edge();
        int e;
        bit trig;
        e = ec;
        upd_q.push_back(bus.Update_DR);
        if (m_active) begin
            if (!bus.Mode) begin
                m_active = 1'b0;
            end else if (e == m_start + 2 * m_n) begin
                m_active    = 1'b0;
                m_done_edge = e;
            end
        end else if (m_done_edge != e - 1) begin
            // Update_DR first sampled high two edges ago, low the edge before.
            trig = bus.Mode && upd_at(e - 2) && !upd_at(e - 3);
            if (trig) begin
                if (bus.Pulse_count == 0) begin
                    m_done_edge = e;
                end else begin
                    m_active = 1'b1;
                    m_start  = e;
                    m_n      = int'(bus.Pulse_count);
                end
            end
        end
        ec++;
    endtask

    function automatic bit exp_gate();
        return m_active && (((ec - 1 - m_start) % 2) == 0);
    endfunction

    function automatic logic [N_CH-1:0] exp_tc();
        return bus.Mode ? (bus.From_BSC & bus.Ch_en & {N_CH{exp_gate()}}) : bus.From_BSC;
    endfunction

    // One TCK cycle: check outputs mid-cycle, then let the edge happen.
    task automatic step();
        #1;
        chk("test_clk", {28'd0, bus.Test_clk}, {28'd0, exp_tc()});
        chk("busy", {31'd0, bus.Busy}, {31'd0, m_active});
        chk("done", {31'd0, bus.Done}, {31'd0, (ec > 0 && m_done_edge == ec - 1)});
        if (bus.Mode && bus.Test_clk[0]) pulse_cnt++;
        if (bus.Mode && (bus.Test_clk[1] || bus.Test_clk[3])) side_cnt++;
        if (bus.Done) done_cnt++;
        @(posedge TCK);
        if (Reset) model_reset();
        else model_edge();
        @(negedge TCK);
    endtask

    task automatic burst(input int pc, input logic [N_CH-1:0] ch, input logic [N_CH-1:0] fb,
                         input int hold, input int cycles);
        bus.Pulse_count = CNT_W'(pc);
        bus.Ch_en       = ch;
        bus.From_BSC    = fb;
        bus.Mode        = 1'b1;
        pulse_cnt = 0;
        side_cnt  = 0;
        done_cnt  = 0;
        bus.Update_DR = 1'b1;
        repeat (hold) step();
        bus.Update_DR = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        Reset           = 1'b1;
        bus.Update_DR   = 1'b0;
        bus.Mode        = 1'b0;
        bus.From_BSC    = 4'b1010;
        bus.Ch_en       = 4'hF;
        bus.Pulse_count = '0;
        model_reset();
        @(negedge TCK);

        // Reset held with bypass clocks toggling
        repeat (4) begin
            bus.From_BSC = ~bus.From_BSC;
            step();
        end
        Reset = 1'b0;
        repeat (2) begin
            bus.From_BSC = ~bus.From_BSC;
            step();
        end

        // Basic three-pulse burst
        burst(3, 4'hF, 4'hF, 2, 12);
        chk("basic_pulses", pulse_cnt, 3);
        chk("basic_done_cnt", done_cnt, 1);

        // Channel masking
        burst(3, 4'b0101, 4'b0111, 2, 12);
        chk("mask_pulses", pulse_cnt, 3);
        chk("mask_side", side_cnt, 0);

        // Zero and maximum counts
        burst(0, 4'hF, 4'hF, 2, 6);
        chk("zero_pulses", pulse_cnt, 0);
        chk("zero_done_cnt", done_cnt, 1);
        burst(15, 4'hF, 4'hF, 2, 40);
        chk("max_pulses", pulse_cnt, 15);
        chk("max_done_cnt", done_cnt, 1);

        // Abort after the second pulse of five
        burst(5, 4'hF, 4'hF, 2, 4);
        bus.Mode = 1'b0;
        repeat (3) step();
        bus.Mode = 1'b1;
        repeat (8) step();
        chk("abort_pulses", pulse_cnt, 2);
        chk("abort_done_cnt", done_cnt, 0);

        // Second Update_DR edge during a burst is ignored
        burst(4, 4'hF, 4'hF, 2, 3);
        bus.Update_DR = 1'b1;
        repeat (2) step();
        bus.Update_DR = 1'b0;
        repeat (12) step();
        chk("retrig_pulses", pulse_cnt, 4);
        chk("retrig_done_cnt", done_cnt, 1);

        // Update_DR held high runs a single burst
        burst(2, 4'hF, 4'hF, 20, 4);
        chk("held_pulses", pulse_cnt, 2);
        chk("held_done_cnt", done_cnt, 1);

        // Asynchronous reset while the gate is open
        burst(5, 4'hF, 4'hF, 2, 1);
        #1;
        chk("pre_reset_clk", {28'd0, bus.Test_clk}, {28'd0, exp_tc()});
        Reset = 1'b1;
        #1;
        chk("async_clk", {28'd0, bus.Test_clk}, 32'd0);
        chk("async_busy", {31'd0, bus.Busy}, 32'd0);
        model_reset();
        step();
        Reset = 1'b0;
        step();
        burst(3, 4'hF, 4'hF, 2, 12);
        chk("post_reset_pulses", pulse_cnt, 3);
        chk("post_reset_done_cnt", done_cnt, 1);

        // Randomised traffic
        bus.Mode = 1'b1;
        repeat (1500) begin
            bus.From_BSC = N_CH'($urandom);
            if ($urandom_range(0, 19) == 0) bus.Ch_en = N_CH'($urandom);
            if ($urandom_range(0, 9) == 0) bus.Pulse_count = CNT_W'($urandom_range(0, 15));
            if (!bus.Update_DR && $urandom_range(0, 5) == 0) bus.Update_DR = 1'b1;
            else if (bus.Update_DR && $urandom_range(0, 2) == 0) bus.Update_DR = 1'b0;
            bus.Mode = ($urandom_range(0, 40) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
